pixel_fetcher: RTL
==================

Name: pixel_fetcher

Overview:
Read-side DMA stage that consumes fetcher_command and fetcher_command_valid from the host-facing controller, and reports fetcher_command_complete back to it. Each command is decoded into a start address, a word count and a stride. The block issues single-word reads on a master read port and buffers the returned 128-bit words in an internal first-word-fall-through FIFO. It presents those words on a valid/ready stream to the downstream pixel datapath.

Parameters:
ADDRESS_SIZE, 36, byte-address width of the master read port
DATA_WIDTH, 128, word width of command, read data and stream
FIFO_DEPTH, 8, output buffer depth in words; must be a power of 2, minimum 2
FIFO_AW, 3, log2(FIFO_DEPTH)

Ports:
clk  input  1  single clock; all logic is on the rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
fetcher_command  input  DATA_WIDTH  command word
fetcher_command_valid  input  1  one-cycle command strobe
fetcher_command_complete  output  1  level; high while the block is in DONE
master_address  output  ADDRESS_SIZE  byte address of the current read
master_rdreq  output  1  read request
master_rdack  input  1  read acknowledge; master_datain is valid in the same cycle
master_datain  input  DATA_WIDTH  read data
fetch_data  output  DATA_WIDTH  FIFO head word
fetch_valid  output  1  FIFO not empty
fetch_ready  input  1  downstream accept
fetch_busy  output  1  high in REQ or DRAIN
cmd_overrun  output  1  sticky; a command arrived while busy

Behaviour:
- Reset (rst=0, asynchronous) forces the following, and also aborts any transfer in progress:
  - state=IDLE
  - every output =0; master_address=0
  - FIFO pointers and count cleared, so any buffered data is discarded
  - cmd_overrun cleared
- Command field decode:
  - [3:0] opcode; must be 4'b0111
  - [19:4] stride, in 16-byte word units; a value of 0 is treated as 1
  - [55:20] count, in 128-bit words
  - [91:56] start byte address
  - [127:92] ignored
- States: IDLE, REQ, DRAIN, DONE.
- IDLE/DONE → accept a command when valid=1 and opcode=0111:
  - latch addr, count and stride
  - fetcher_command_complete drops the next cycle
  - if count=0, go to DONE (one cycle after the strobe); otherwise go to REQ
- IDLE/DONE with a bad opcode: command ignored; state and complete are unchanged.
- REQ/DRAIN with valid=1: command ignored and cmd_overrun is set to 1.
- REQ read sequencing:
  - master_rdreq is registered. It rises only when remaining>0 and FIFO count<FIFO_DEPTH.
  - Once high, it is held with master_address stable until master_rdack=1. Only one read is ever outstanding.
  - On a clock edge with rdreq=1 and rdack=1:
    - master_datain is written to the FIFO
    - rdreq is cleared
    - address += stride*16 (modulo 2^ADDRESS_SIZE; wraps silently)
    - remaining decrements by 1
  - rdreq may rise again on the following edge, so peak throughput is one word per 2 cycles.
  - rdack while rdreq=0 is ignored.
  - When remaining reaches 0 after an ack, go to DRAIN.
- DRAIN → DONE when the FIFO is empty. fetcher_command_complete=1 in DONE and holds there until the next accepted command.
- FIFO behaviour:
  - fetch_valid = count≠0; fetch_data = head word (first-word-fall-through).
  - A pop happens on fetch_valid & fetch_ready.
  - A push and a pop in the same cycle leave the count unchanged and are legal even when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH.
- Backpressure: while the FIFO is full, no new rdreq is raised. A rdreq already raised is always safe to complete, because space was checked when it was raised.
- fetch_busy = state∈{REQ, DRAIN}.

Test Plan:
- Basic read: count=4, addr=0x100, stride=1, fetch_ready=1, memory acks one cycle after each rdreq. Required:
  - reads at 0x100, 0x110, 0x120, 0x130
  - 4 words out, in order
  - complete rises after the last pop and stays high
- Strided read: stride=3, count=2, addr=0xFFFFFFFF0. Required: addresses 0xFFFFFFFF0, then 0x000000020 (wrap).
- Backpressure: FIFO_DEPTH=8, count=12, fetch_ready=0 for 40 cycles. Required:
  - exactly 8 acks, after which rdreq stays low
  - releasing ready yields all 12 words with no loss
  - complete is asserted only after the 12th pop
- Edge commands:
  - count=0 → complete=1 one cycle after the strobe, with no rdreq
  - opcode=0011 → ignored
  - valid during REQ → cmd_overrun=1 and the current transfer is unaffected
- Mid-transfer reset: drive rst=0 while rdreq=1 and the FIFO holds 3 words. Required:
  - all outputs go to 0 immediately
  - after release, a new count=1 command completes normally

Source files
------------

// File: rtl/pixel_fetcher.sv
// Read-side DMA stage: decodes a fetch command, issues single-word strided reads,
// and streams the returned words out through a first-word-fall-through buffer.
module pixel_fetcher #(
   parameter int ADDRESS_SIZE = 36,
   parameter int DATA_WIDTH   = 128,
   parameter int FIFO_DEPTH   = 8,
   parameter int FIFO_AW      = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   fetcher_command,
   input  logic                    fetcher_command_valid,
   output logic                    fetcher_command_complete,
   output logic [ADDRESS_SIZE-1:0] master_address,
   output logic                    master_rdreq,
   input  logic                    master_rdack,
   input  logic [DATA_WIDTH-1:0]   master_datain,
   output logic [DATA_WIDTH-1:0]   fetch_data,
   output logic                    fetch_valid,
   input  logic                    fetch_ready,
   output logic                    fetch_busy,
   output logic                    cmd_overrun
);

   localparam int CNT_W = 36;
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]        remain_q, remain_d;
   logic [15:0]             stride_q, stride_d;
   logic                    rdreq_q, rdreq_d;
   logic                    overrun_q, overrun_d;

   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]        cnt_q, cnt_d;
   logic                    push, pop, full;

   logic [3:0]              cmd_op;
   logic [15:0]             cmd_stride;
   logic [CNT_W-1:0]        cmd_count;
   logic [ADDRESS_SIZE-1:0] cmd_addr;

   assign cmd_op     = fetcher_command[3:0];
   assign cmd_stride = fetcher_command[19:4];
   assign cmd_count  = fetcher_command[55:20];
   assign cmd_addr   = fetcher_command[56 +: ADDRESS_SIZE];

   assign full = (cnt_q == DEPTH_C);
   assign pop  = (cnt_q != '0) && fetch_ready;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      stride_d  = stride_q;
      rdreq_d   = rdreq_q;
      overrun_d = overrun_q;
      push      = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (fetcher_command_valid && cmd_op == 4'b0111) begin
               addr_d   = cmd_addr;
               remain_d = cmd_count;
               stride_d = (cmd_stride == '0) ? 16'd1 : cmd_stride;
               state_d  = (cmd_count == '0) ? DONE : REQ;
            end
         end
         REQ: begin
            if (fetcher_command_valid) overrun_d = 1'b1;
            if (rdreq_q) begin
               if (master_rdack) begin
                  push     = 1'b1;
                  rdreq_d  = 1'b0;
                  addr_d   = addr_q + ADDRESS_SIZE'({stride_q, 4'b0000});
                  remain_d = remain_q - 1'b1;
                  if (remain_q == CNT_W'(1)) state_d = DRAIN;
               end
            end else if (remain_q != '0 && !full) begin
               // Space is reserved at raise time, so the eventual ack always fits.
               rdreq_d = 1'b1;
            end
         end
         DRAIN: begin
            if (fetcher_command_valid) overrun_d = 1'b1;
            if (cnt_q == '0) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         remain_q  <= '0;
         stride_q  <= '0;
         rdreq_q   <= 1'b0;
         overrun_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         stride_q  <= stride_d;
         rdreq_q   <= rdreq_d;
         overrun_q <= overrun_d;
         cnt_q     <= cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= master_datain;
   end

   // Storage is not reset, so the head is masked while the buffer is empty.
   assign fetch_data               = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign fetch_valid              = (cnt_q != '0);
   assign master_rdreq             = rdreq_q;
   assign master_address           = addr_q;
   assign fetcher_command_complete = (state_q == DONE);
   assign fetch_busy               = (state_q == REQ) || (state_q == DRAIN);
   assign cmd_overrun              = overrun_q;

endmodule
